// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 types, rotate/shift helpers, K table and schedule FSM states
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t shr(input word_t x, input int unsigned n);
    return x >> n;
  endfunction

  localparam word_t K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/mod_sched_sigma.sv
// rtl/mod_sched_sigma.sv - combinational SHA-256 small sigma (s0 when SEL_S1=0, s1 when SEL_S1=1)
module mod_sched_sigma
  import sha256_pkg::*;
#(
  parameter bit SEL_S1 = 1'b0
) (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);

  // s0 = ROTR7 ^ ROTR18 ^ SHR3, s1 = ROTR17 ^ ROTR19 ^ SHR10
  assign y_o = SEL_S1 ? (rotr(x_i, 17) ^ rotr(x_i, 19) ^ shr(x_i, 10))
                      : (rotr(x_i, 7)  ^ rotr(x_i, 18) ^ shr(x_i, 3));

endmodule

// File: rtl/mod_w_sched_exp.sv
// rtl/mod_w_sched_exp.sv - SHA-256 message schedule: 16 words in, W[0..63] out; SCHED_K_ROM_EN adds K_OUT
module mod_w_sched_exp
  import sha256_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 16,
  parameter int ROUNDS      = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [WORD_W-1:0] M_IN,
  input  logic              M_VALID,
  output logic              M_READY,
  output logic [WORD_W-1:0] W_OUT,
  output logic [5:0]        I_OUT,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic              BUSY,
`ifdef SCHED_K_ROM_EN
  output logic [WORD_W-1:0] K_OUT,
`endif
  output logic              DONE
);

  state_t          state_q, state_d;
  word_t [15:0]    win_q, win_d;    // win[0]=W[t-16] ... win[15]=W[t-1]
  logic [6:0]      cnt_q, cnt_d;    // index of the next word to produce, 0..64
  word_t           w_q, w_d;
  logic [5:0]      i_q, i_d;
  logic            vld_q, vld_d;
  logic            out_ld;          // output register takes a new word this cycle
  logic            free;
  word_t           s0_w, s1_w, w_new;

  mod_sched_sigma #(.SEL_S1(1'b0)) u_s0 (.x_i(win_q[1]),  .y_o(s0_w));
  mod_sched_sigma #(.SEL_S1(1'b1)) u_s1 (.x_i(win_q[14]), .y_o(s1_w));

  assign w_new = s1_w + win_q[9] + s0_w + win_q[0];
  assign free  = !vld_q || W_READY;

  // Next-state logic: FSM, window shift and output-register load
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    i_d     = i_q;
    vld_d   = vld_q;
    out_ld  = 1'b0;
    M_READY = 1'b0;
    DONE    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_LOAD;
          cnt_d   = 7'd0;
        end
      end
      ST_LOAD: begin
        M_READY = free;
        if (free) begin
          vld_d = M_VALID;
          if (M_VALID) begin
            out_ld = 1'b1;
            win_d  = {M_IN, win_q[15:1]};
            w_d    = M_IN;
            i_d    = cnt_q[5:0];
            cnt_d  = cnt_q + 7'd1;
            if (cnt_q == 7'(BLOCK_WORDS - 1)) state_d = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        if (free) begin
          out_ld = 1'b1;
          vld_d  = 1'b1;
          win_d  = {w_new, win_q[15:1]};
          w_d    = w_new;
          i_d    = cnt_q[5:0];
          cnt_d  = cnt_q + 7'd1;
          if (cnt_q == 7'(ROUNDS - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Output register holds W[63]; the block ends when it is taken
        if (W_READY) begin
          vld_d   = 1'b0;
          DONE    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 7'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, window and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      w_q     <= '0;
      i_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      i_q     <= i_d;
      vld_q   <= vld_d;
    end
  end

`ifdef SCHED_K_ROM_EN
  logic [WORD_W-1:0] k_q;

  // K register loads with the same index as W so K_OUT always matches I_OUT
  always_ff @(posedge CLK) begin
    if (RESET) begin
      k_q <= '0;
    end else if (out_ld) begin
      k_q <= K_TAB[cnt_q[5:0]];
    end
  end

  assign K_OUT = k_q;
`endif

  assign W_OUT   = w_q;
  assign I_OUT   = i_q;
  assign W_VALID = vld_q;
  assign BUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mod_w_sched_exp.sv
// tb/tb_mod_w_sched_exp.sv - self-checking bench for mod_w_sched_exp; honours SCHED_K_ROM_EN
module tb_mod_w_sched_exp;

  typedef logic [31:0] wd_t;

  typedef struct {
    wd_t m0;
    wd_t m15;
    int  ia;
    wd_t ea;
    int  ib;
    wd_t eb;
  } vec_t;

  logic        CLK, RESET, START, M_VALID, M_READY, W_VALID, W_READY, BUSY, DONE;
  logic [31:0] M_IN, W_OUT;
  logic [5:0]  I_OUT;
`ifdef SCHED_K_ROM_EN
  logic [31:0] K_OUT;
  wd_t         k_at0, k_at63;
`endif

  int checks = 0;
  int errors = 0;

  mod_w_sched_exp dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .M_IN(M_IN), .M_VALID(M_VALID), .M_READY(M_READY),
    .W_OUT(W_OUT), .I_OUT(I_OUT), .W_VALID(W_VALID), .W_READY(W_READY),
    .BUSY(BUSY),
`ifdef SCHED_K_ROM_EN
    .K_OUT(K_OUT),
`endif
    .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic wd_t rr(input wd_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule straight from the SHA-256 recurrence over a full array
  function automatic void model(input wd_t m [16], output wd_t w [64]);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = m[t];
      else w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
  endfunction

  task automatic do_reset();
    RESET = 1'b1; START = 1'b0; M_VALID = 1'b0; M_IN = '0; W_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic run_block(input wd_t m [16], input bit rnd, input bit hold_start,
                           input int abort_at, output wd_t got [64], output int ndone,
                           output int c_first_m, output int c_first_w, output int c_done,
                           output int order_bad, output int stall_bad,
                           output bit busy1, output bit busy2, output bit aborted);
    int  cyc, mi, wi, post;
    bit  pv_stall, done_seen;
    wd_t pw;
    logic [5:0] pi;
    for (int i = 0; i < 64; i++) got[i] = '0;
    ndone = 0; c_first_m = -1; c_first_w = -1; c_done = -1;
    order_bad = 0; stall_bad = 0; busy1 = 1'b1; busy2 = 1'b0; aborted = 1'b0;
    cyc = 0; mi = 0; wi = 0; post = 0; pv_stall = 1'b0; done_seen = 1'b0;
    pw = '0; pi = '0;
    while (cyc < 3000) begin
      START   = hold_start ? 1'b1 : (cyc == 0);
      M_VALID = (mi < 16) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      M_IN    = (mi < 16) ? m[mi] : $urandom;
      W_READY = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (post == 1) busy1 = BUSY;
      if (post == 2) busy2 = BUSY;
      if (pv_stall && (!W_VALID || W_OUT !== pw || I_OUT !== pi)) stall_bad++;
      if (W_VALID && int'(I_OUT) == abort_at) begin
        RESET   = 1'b1;
        aborted = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0; START = 1'b0; M_VALID = 1'b0;
        break;
      end
`ifdef SCHED_K_ROM_EN
      if (W_VALID && I_OUT == 6'd0)  k_at0  = K_OUT;
      if (W_VALID && I_OUT == 6'd63) k_at63 = K_OUT;
`endif
      if (M_VALID && M_READY) begin
        if (c_first_m < 0) c_first_m = cyc;
        mi++;
      end
      if (W_VALID && c_first_w < 0) c_first_w = cyc;
      if (W_VALID && W_READY) begin
        if (int'(I_OUT) != wi) order_bad++;
        if (wi < 64) got[wi] = W_OUT;
        wi++;
      end
      if (DONE) begin
        ndone++;
        if (!done_seen) c_done = cyc;
        done_seen = 1'b1;
      end
      pv_stall = W_VALID && !W_READY;
      pw = W_OUT;
      pi = I_OUT;
      @(posedge CLK);
      #1;
      cyc++;
      if (done_seen) begin
        post++;
        if (post == 3) break;
      end
    end
    START = 1'b0;
    M_VALID = 1'b0;
  endtask

  initial begin
    vec_t vt [3];
    wd_t  m [16];
    wd_t  exp_w [64];
    wd_t  got [64];
    wd_t  abc_ref [64];
    int   nd, cfm, cfw, cd, ob, sb, bad;
    bit   b1, b2, ab;

    vt[0] = '{m0: 32'h0000_0000, m15: 32'h0000_0000, ia: 16, ea: 32'h0000_0000, ib: 63, eb: 32'h0000_0000};
    vt[1] = '{m0: 32'h0000_0001, m15: 32'h0000_0000, ia: 16, ea: 32'h0000_0001, ib: 17, eb: 32'h0000_0000};
    vt[2] = '{m0: 32'h6162_6380, m15: 32'h0000_0018, ia: 16, ea: 32'h6162_6380, ib: 17, eb: 32'h000F_0000};

    do_reset();
    #1;
    check("rst_m_ready", {31'd0, M_READY}, 32'd0);
    check("rst_w_valid", {31'd0, W_VALID}, 32'd0);
    check("rst_w_out",   W_OUT, 32'd0);
    check("rst_i_out",   {26'd0, I_OUT}, 32'd0);
    check("rst_busy",    {31'd0, BUSY}, 32'd0);
    check("rst_done",    {31'd0, DONE}, 32'd0);
`ifdef SCHED_K_ROM_EN
    check("rst_k_out",   K_OUT, 32'd0);
`endif

    // Directed blocks with the consumer always ready
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 16; i++) m[i] = '0;
      m[0] = vt[v].m0;
      m[15] = vt[v].m15;
      model(m, exp_w);
      run_block(m, 1'b0, 1'b0, -1, got, nd, cfm, cfw, cd, ob, sb, b1, b2, ab);
      check($sformatf("v%0d_word_a", v), got[vt[v].ia], vt[v].ea);
      check($sformatf("v%0d_word_b", v), got[vt[v].ib], vt[v].eb);
      bad = 0;
      for (int i = 0; i < 64; i++) if (got[i] !== exp_w[i]) bad++;
      check($sformatf("v%0d_seq_bad", v), bad, 0);
      check($sformatf("v%0d_order_bad", v), ob, 0);
      check($sformatf("v%0d_done_cnt", v), nd, 1);
      check($sformatf("v%0d_w0_lat", v), cfw - cfm, 1);
      check($sformatf("v%0d_done_lat", v), cd - cfm, 64);
      check($sformatf("v%0d_idle_after", v), {31'd0, b1}, 32'd0);
      if (v == 2) abc_ref = got;
    end

`ifdef SCHED_K_ROM_EN
    check("k_at_0", k_at0, 32'h428a2f98);
    check("k_at_63", k_at63, 32'hc67178f2);
`endif

    // abc block with random backpressure must match the unstalled run
    for (int i = 0; i < 16; i++) m[i] = '0;
    m[0] = 32'h6162_6380;
    m[15] = 32'h0000_0018;
    run_block(m, 1'b1, 1'b0, -1, got, nd, cfm, cfw, cd, ob, sb, b1, b2, ab);
    bad = 0;
    for (int i = 0; i < 64; i++) if (got[i] !== abc_ref[i]) bad++;
    check("abc_rnd_seq_bad", bad, 0);
    check("abc_rnd_stall_bad", sb, 0);
    check("abc_rnd_done_cnt", nd, 1);

    // Random blocks under random flow control
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) m[i] = $urandom;
      model(m, exp_w);
      run_block(m, 1'b1, 1'b0, -1, got, nd, cfm, cfw, cd, ob, sb, b1, b2, ab);
      bad = 0;
      for (int i = 0; i < 64; i++) if (got[i] !== exp_w[i]) bad++;
      check($sformatf("rnd%0d_seq_bad", r), bad, 0);
      check($sformatf("rnd%0d_order_bad", r), ob, 0);
      check($sformatf("rnd%0d_stall_bad", r), sb, 0);
      check($sformatf("rnd%0d_done_cnt", r), nd, 1);
    end

    // START held high: the next block starts only once IDLE is re-entered
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    model(m, exp_w);
    run_block(m, 1'b0, 1'b1, -1, got, nd, cfm, cfw, cd, ob, sb, b1, b2, ab);
    check("hold_done_cnt", nd, 1);
    check("hold_w63", got[63], exp_w[63]);
    check("hold_busy_after_done", {31'd0, b1}, 32'd0);
    check("hold_busy_restart", {31'd0, b2}, 32'd1);
    do_reset();

    // Reset at I_OUT=30 abandons the block
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    run_block(m, 1'b0, 1'b0, 30, got, nd, cfm, cfw, cd, ob, sb, b1, b2, ab);
    check("abort_taken", {31'd0, ab}, 32'd1);
    check("abort_w_valid", {31'd0, W_VALID}, 32'd0);
    check("abort_busy", {31'd0, BUSY}, 32'd0);
    check("abort_done", {31'd0, DONE}, 32'd0);
    check("abort_w_out", W_OUT, 32'd0);
    check("abort_i_out", {26'd0, I_OUT}, 32'd0);
    check("abort_no_done", nd, 0);

    // Fresh block after the abort
    for (int i = 0; i < 16; i++) m[i] = $urandom;
    model(m, exp_w);
    run_block(m, 1'b0, 1'b0, -1, got, nd, cfm, cfw, cd, ob, sb, b1, b2, ab);
    check("fresh_w0", got[0], m[0]);
    bad = 0;
    for (int i = 0; i < 64; i++) if (got[i] !== exp_w[i]) bad++;
    check("fresh_seq_bad", bad, 0);
    check("fresh_done_cnt", nd, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
